seg7_scan_driver: RTL

//  Time-multiplexed 8-digit seven-segment driver, directly downstream of the circular-shift stage.

---
 rtl/seg7_scan_driver.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed seven-segment driver.
//
// Scans num_digits digits, one per slot of P = clk_freq/scan_freqHz clocks.
// Each slot starts with blank_cycles clocks with every anode off, which
// suppresses ghosting, and then drives the active digit for the rest of the
// slot. The input word and the decimal points are captured once per frame,
// at the wrap after the last digit, so a shift upstream cannot tear the
// displayed value. Segments and anodes are active-low, ordered {g,f,e,d,c,b,a}.
//
// Optional feature macro: LEADING_ZERO_BLANK_EN
//   When defined, digits above the most-significant non-zero nibble of the
//   latched frame show all segments off. Their anode is still driven, and dp
//   still follows its bit. Digit 0 is always shown.
//
// state | meaning
// IDLE  | display dark, waiting for enable; prescaler and digit index cleared
// BLANK | first blank_cycles clocks of a slot, all anodes off
// DRIVE | remainder of the slot, anode digit_idx on with its decoded nibble
module seg7_scan_driver #(
  parameter logic [27:0] clk_freq     = 28'd100_000000,
  parameter logic [27:0] scan_freqHz  = 28'd1000,
  parameter int          num_digits   = 8,
  parameter int          blank_cycles = 16   // must be >= 1, and P >= blank_cycles+1
) (
  input  logic                      sys_clk_in,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [4*num_digits-1:0]   binary_in,
  input  logic [num_digits-1:0]     dp_in,
  output logic [num_digits-1:0]     an_out,
  output logic [6:0]                seg_out,
  output logic                      dp_out,
  output logic                      frame_done
);

  localparam int unsigned SLOT = 32'(clk_freq / scan_freqHz);
  localparam int CW = (SLOT > 1) ? $clog2(SLOT) : 1;
  localparam int IW = (num_digits > 1) ? $clog2(num_digits) : 1;
  localparam logic [CW-1:0] SLOT_LAST  = CW'(SLOT - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(blank_cycles - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(num_digits - 1);

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*num_digits-1:0] frame_q;
  logic [num_digits-1:0]   dpl_q;
  logic                    latch;
  logic                    tick;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    digit_lit;
  logic [num_digits-1:0]   an_d;
  logic [6:0]              seg_d;
  logic                    dp_d;
  logic                    fd_d;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign tick = (cnt_q == SLOT_LAST);

  // Select the latched nibble and dp bit for the digit currently scanned.
  always_comb begin
    cur_nib = 4'h0;
    cur_dp  = 1'b0;
    for (int k = 0; k < num_digits; k++) begin
      if (idx_q == IW'(k)) begin
        cur_nib = frame_q[4*k +: 4];
        cur_dp  = dpl_q[k];
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [IW-1:0] msd;

  // Most-significant non-zero digit of the latched frame (0 when all zero).
  always_comb begin
    msd = '0;
    for (int k = 0; k < num_digits; k++) begin
      if (frame_q[4*k +: 4] != 4'h0) msd = IW'(k);
    end
  end

  assign digit_lit = (idx_q <= msd);
`else
  assign digit_lit = 1'b1;
`endif

  // Next-state, prescaler, digit index and next registered output values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    latch   = 1'b0;
    fd_d    = 1'b0;
    an_d    = '1;
    seg_d   = 7'h7F;
    dp_d    = 1'b1;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = BLANK;
          cnt_d   = '0;
          idx_d   = '0;
          latch   = 1'b1;
          fd_d    = 1'b1;
        end
        BLANK: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == BLANK_LAST) state_d = DRIVE;
        end
        DRIVE: begin
          if (tick) begin
            cnt_d   = '0;
            state_d = BLANK;
            if (idx_q == IDX_LAST) begin
              idx_d = '0;
              latch = 1'b1;
              fd_d  = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end
    // Entering or staying in DRIVE never changes the digit index.
    if (state_d == DRIVE) begin
      an_d[idx_q] = 1'b0;
      seg_d       = digit_lit ? seg_decode(cur_nib) : 7'h7F;
      dp_d        = ~cur_dp;
    end
  end

  // State, counters, frame latch and glitch-free registered outputs.
  always_ff @(posedge sys_clk_in or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      frame_q    <= '0;
      dpl_q      <= '0;
      an_out     <= '1;
      seg_out    <= 7'h7F;
      dp_out     <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      if (latch) begin
        frame_q <= binary_in;
        dpl_q   <= dp_in;
      end
      an_out     <= an_d;
      seg_out    <= seg_d;
      dp_out     <= dp_d;
      frame_done <= fd_d;
    end
  end

endmodule
